lsu_ctrl: RTL and testbench

//  Load-store unit for the MEM stage; sits directly upstream of data_memory and drives its

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 55 +++++
 rtl/lsu_ctrl.sv | 115 +++++++++++
 tb/tb_lsu_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load-store unit: funct3 codes, access size, FSM state.
// Also small helpers for funct3 legality and word-boundary split detection.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic {
    S_IDLE,
    S_SECOND
  } state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  function automatic logic is_split(input size_e sz,
                                    input logic [1:0] off);
    return ((sz == SZ_H) && (off == 2'd3)) ||
           ((sz == SZ_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane shifter: merges store bytes into a read word and aligns load bytes.
// Ports: rdata/st_data/off/size/part in; wdata (merged word), ld_bytes out.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] st_data,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        part,
  output logic [31:0] wdata,
  output logic [31:0] ld_bytes
);

  logic [3:0]  smask;
  logic [7:0]  m_sh;
  logic [63:0] st_sh;
  logic [3:0]  lane_m;
  logic [31:0] lane_d;
  logic [2:0]  hi_n;

  always_comb begin
    smask = 4'b0000;
    unique case (size)
      SZ_B:    smask = 4'b0001;
      SZ_H:    smask = 4'b0011;
      SZ_W:    smask = 4'b1111;
      default: smask = 4'b0000;
    endcase
  end

  // Shift into a two-word window; the upper word holds
  // the bytes that spill into the next memory word.
  assign st_sh  = {32'b0, st_data} << {off, 3'b000};
  assign m_sh   = {4'b0, smask} << off;
  assign lane_m = part ? m_sh[7:4] : m_sh[3:0];
  assign lane_d = part ? st_sh[63:32] : st_sh[31:0];

  always_comb begin
    wdata = rdata;
    for (int i = 0; i < 4; i++) begin
      if (lane_m[i]) wdata[8*i +: 8] = lane_d[8*i +: 8];
    end
  end

  // Second half: bytes of W+1 land above the 4-OFF
  // bytes already captured from W.
  assign hi_n = 3'd4 - {1'b0, off};

  always_comb begin
    if (part) ld_bytes = rdata << {hi_n, 3'b000};
    else      ld_bytes = rdata >> {off, 3'b000};
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load-store unit: byte requests to word accesses, RMW, split, extend.
// Ports: i_lsu_* request, o_ld_data/o_lsu_stall/o_addr_err, o_dmem_*/i_dmem_rdata.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 712
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_req,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_lsu_stall,
  output logic        o_addr_err,
  output logic [15:0] o_dmem_addr,
  output logic        o_dmem_wren,
  output logic [31:0] o_dmem_wdata,
  input  logic [31:0] i_dmem_rdata
);

  localparam logic [16:0] LIM = 17'(DMEM_WORDS);

  state_e      state;
  logic [31:0] lo_q;
  logic [15:0] w_idx;
  logic [16:0] w_nxt;
  logic [1:0]  off;
  size_e       size;
  logic        split;
  logic        range_bad;
  logic        go_split;
  logic        part;
  logic        ld_ok;
  logic [31:0] ld_bytes;
  logic [31:0] raw;
  logic [31:0] ext;
  logic        unused_hi;

  assign w_idx = i_lsu_addr[17:2];
  assign w_nxt = {1'b0, w_idx} + 17'd1;
  assign off   = i_lsu_addr[1:0];
  assign size  = size_e'(i_lsu_funct3[1:0]);
  assign split = is_split(size, off);
  assign part  = (state == S_SECOND);

  assign unused_hi = ^i_lsu_addr[31:18];

  // A split whose second word is out of range is
  // rejected up front, so W+1 never wraps.
  assign range_bad = ({1'b0, w_idx} >= LIM) |
                     (split & (w_nxt >= LIM));

  assign o_addr_err = i_lsu_req & ~i_reset &
                      (~f3_legal(i_lsu_funct3) | range_bad);

  assign go_split = ~part & i_lsu_req & split &
                    ~o_addr_err & ~i_reset;

  assign o_lsu_stall = go_split;
  assign o_dmem_addr = part ? w_nxt[15:0] : w_idx;
  assign o_dmem_wren = i_lsu_req & i_lsu_wren &
                       ~o_addr_err & ~i_reset;

  lsu_lane_align u_align (
    .rdata    (i_dmem_rdata),
    .st_data  (i_st_data),
    .off      (off),
    .size     (size),
    .part     (part),
    .wdata    (o_dmem_wdata),
    .ld_bytes (ld_bytes)
  );

  assign raw = part ? (lo_q | ld_bytes) : ld_bytes;

  always_comb begin
    ext = raw;
    unique case (size)
      SZ_B:
        ext = i_lsu_funct3[2] ? {24'b0, raw[7:0]}
                              : {{24{raw[7]}}, raw[7:0]};
      SZ_H:
        ext = i_lsu_funct3[2] ? {16'b0, raw[15:0]}
                              : {{16{raw[15]}}, raw[15:0]};
      default:
        ext = raw;
    endcase
  end

  assign ld_ok = i_lsu_req & ~i_lsu_wren &
                 ~o_addr_err & ~i_reset;
  assign o_ld_data = ld_ok ? ext : 32'h0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
      lo_q  <= 32'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go_split) begin
            state <= S_SECOND;
            lo_q  <= ld_bytes;
          end
        end
        S_SECOND: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural word memory.
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_lsu_ctrl;

  localparam int NW = 712;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        req;
  logic        wren;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] st;
  logic [31:0] ld;
  logic        stall;
  logic        err;
  logic [15:0] d_addr;
  logic        d_wren;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;

  logic [31:0] mem [0:NW-1];

  int checks = 0;
  int failures = 0;
  int scnt = 0;

  typedef struct {
    string       tag;
    logic [31:0] ld;
    logic        err;
    logic        wr;
    int          stalls;
  } exp_t;

  exp_t q[$];

  always #5 i_clk = ~i_clk;

  lsu_ctrl #(.DMEM_WORDS(NW)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_lsu_req    (req),
    .i_lsu_wren   (wren),
    .i_lsu_funct3 (f3),
    .i_lsu_addr   (addr),
    .i_st_data    (st),
    .o_ld_data    (ld),
    .o_lsu_stall  (stall),
    .o_addr_err   (err),
    .o_dmem_addr  (d_addr),
    .o_dmem_wren  (d_wren),
    .o_dmem_wdata (d_wdata),
    .i_dmem_rdata (d_rdata)
  );

  always_comb begin
    d_rdata = 32'h0;
    if (int'(d_addr) < NW) d_rdata = mem[int'(d_addr)];
  end

  always @(posedge i_clk) begin
    if (d_wren && int'(d_addr) < NW)
      mem[int'(d_addr)] <= d_wdata;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, req_v);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (i_reset) begin
      scnt = 0;
    end else if (req) begin
      if (stall) begin
        scnt++;
      end else begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion actual=1 required=0");
        end else begin
          e = q.pop_front();
          chk({e.tag, "_ld"}, ld, e.ld);
          chk({e.tag, "_err"}, 32'(err), 32'(e.err));
          chk({e.tag, "_wren"}, 32'(d_wren), 32'(e.wr));
          chk({e.tag, "_stalls"}, 32'(scnt), 32'(e.stalls));
        end
        scnt = 0;
      end
    end
  end

  task automatic op(input string tag,
                    input logic w,
                    input logic [2:0] fn,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [31:0] e_ld,
                    input logic e_err,
                    input logic e_wr,
                    input int e_st);
    q.push_back('{tag: tag, ld: e_ld, err: e_err,
                  wr: e_wr, stalls: e_st});
    req  = 1'b1;
    wren = w;
    f3   = fn;
    addr = a;
    st   = d;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (!stall) break;
    end
    @(posedge i_clk);
    #1;
    req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = 32'h0;
    i_reset = 1'b1;
    req  = 1'b1;
    wren = 1'b0;
    f3   = 3'b010;
    addr = 32'h8;
    st   = 32'h0;
    mem[2] = 32'h12345678;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_wren", 32'(d_wren), 32'h0);
    chk("rst_ld", ld, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    req = 1'b0;

    // Reset arriving in the second half of a split store.
    mem[4] = 32'hA5A5A5A5;
    mem[5] = 32'h5A5A5A5A;
    @(posedge i_clk);
    #1;
    req  = 1'b1;
    wren = 1'b1;
    f3   = 3'b010;
    addr = 32'h11;
    st   = 32'h44332211;
    @(negedge i_clk);
    chk("rsplit_stall1", 32'(stall), 32'h1);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    #1;
    chk("rsplit_stall0", 32'(stall), 32'h0);
    chk("rsplit_wren0", 32'(d_wren), 32'h0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    req = 1'b0;
    chk("rsplit_mem4", mem[4], 32'h332211A5);
    chk("rsplit_mem5", mem[5], 32'h5A5A5A5A);

    // Aligned word.
    op("sw8", 1, 3'b010, 32'h8, 32'hDEADBEEF, 0, 0, 1, 0);
    chk("sw8_mem2", mem[2], 32'hDEADBEEF);
    op("lw8", 0, 3'b010, 32'h8, 0, 32'hDEADBEEF, 0, 0, 0);

    // Byte store read-modify-write and extension.
    mem[1] = 32'h11223344;
    op("sb5", 1, 3'b000, 32'h5, 32'h123456AB, 0, 0, 1, 0);
    chk("sb5_mem1", mem[1], 32'h1122AB44);
    op("lb5", 0, 3'b000, 32'h5, 0, 32'hFFFFFFAB, 0, 0, 0);
    op("lbu5", 0, 3'b100, 32'h5, 0, 32'h000000AB, 0, 0, 0);
    op("lh5", 0, 3'b001, 32'h5, 0, 32'h000022AB, 0, 0, 0);

    // Split half-word loads.
    mem[3] = 32'h80AABBCC;
    mem[4] = 32'h000000FF;
    op("lhF", 0, 3'b001, 32'hF, 0, 32'hFFFFFF80, 0, 0, 1);
    op("lhuF", 0, 3'b101, 32'hF, 0, 32'h0000FF80, 0, 0, 1);

    // Split word store, then read it back.
    mem[4] = 32'hA0B0C0D0;
    mem[5] = 32'hE0F00102;
    op("sw11", 1, 3'b010, 32'h11, 32'h44332211, 0, 0, 1, 1);
    chk("sw11_mem4", mem[4], 32'h332211D0);
    chk("sw11_mem5", mem[5], 32'hE0F00144);
    op("lw11", 0, 3'b010, 32'h11, 0, 32'h44332211, 0, 0, 1);

    // Split half-word store.
    op("sh7", 1, 3'b001, 32'h7, 32'h0000BEEF, 0, 0, 1, 1);
    chk("sh7_mem1", mem[1], 32'hEF22AB44);
    chk("sh7_mem2", mem[2], 32'hDEADBEBE);

    // Top of memory and range errors.
    mem[711] = 32'hCAFEF00D;
    op("lw_last", 0, 3'b010, 32'd2844, 0, 32'hCAFEF00D, 0, 0, 0);
    op("lw_oob", 0, 3'b010, 32'd2845, 0, 0, 1, 0, 0);
    op("sw_oob", 1, 3'b010, 32'd2848, 32'h55AA55AA, 0, 1, 0, 0);
    chk("sw_oob_last", mem[711], 32'hCAFEF00D);

    // Illegal funct3.
    op("ld_f3_011", 0, 3'b011, 32'h8, 0, 0, 1, 0, 0);
    op("st_f3_110", 1, 3'b110, 32'h8, 32'h01020304, 0, 1, 0, 0);
    chk("st_f3_mem2", mem[2], 32'hDEADBEBE);

    repeat (3) @(posedge i_clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule
